// File: rtl/mem_hs_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master)
// and the data memory (slave).
interface mem_hs_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dm_req;
    logic [3:0]        dm_wen;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;

    modport master (
        output dm_req, dm_wen, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_wen, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_hs_stage.sv
// Handshaked MEM stage: req/ack data memory, load extend, store lanes.
// Optional MEM_TIMEOUT_EN: bus error when dm_ack never arrives.
module mem_hs_stage #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              MEM_valid,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic              in_rf_wen,
    input  logic [4:0]        in_rf_wdest,
    input  logic [31:0]       in_pc,
    input  logic              in_exc_flag,
    input  logic [1:0]        in_exc_type,
    mem_hs_stage_if.master    dm,
    output logic              MEM_over,
    output logic [72:0]       MEM_WB_bus,
    output logic [31:0]       MEM_pc,
    output logic              busy,
    output logic              mem_exception_flag,
    output logic [1:0]        mem_exception_type
);

    if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, nstate;

    logic              h_load, h_store, h_uns;
    logic              h_rfw, h_exc;
    logic [1:0]        h_size, h_etype;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata, h_pc;
    logic [4:0]        h_dest;

    logic              f_load, f_store, f_rfw, f_exc;
    logic [1:0]        f_size, f_etype;
    logic [ADDR_W-1:0] f_addr;
    logic [4:0]        f_dest;
    logic [31:0]       f_pc;

    logic        capture, finish, mem_op, mis, direct, to_hit;
    logic        exc_f;
    logic [1:0]  exc_t;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_ext, wb;
    logic [3:0]  lane_wen;
    logic [31:0] lane_wd;
    logic [72:0] bus_q, bus_d;
    logic        mf_q, mf_d;
    logic [1:0]  mt_q, mt_d;

    function automatic logic misal(
        input logic [1:0] sz,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        unique case (1'b1)
            sz[1]:         m = (a != 2'b00);
            (sz == 2'b01): m = a[0];
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

    assign capture = (state == IDLE) && MEM_valid;

    // Decisions at capture time use the live inputs, later the held copy.
    always_comb begin
        f_load  = h_load;
        f_store = h_store;
        f_size  = h_size;
        f_addr  = h_addr;
        f_rfw   = h_rfw;
        f_dest  = h_dest;
        f_pc    = h_pc;
        f_exc   = h_exc;
        f_etype = h_etype;
        if (state == IDLE) begin
            f_load  = in_load;
            f_store = in_store;
            f_size  = in_size;
            f_addr  = in_addr;
            f_rfw   = in_rf_wen;
            f_dest  = in_rf_wdest;
            f_pc    = in_pc;
            f_exc   = in_exc_flag;
            f_etype = in_exc_type;
        end
    end

    assign mem_op = f_load | f_store;
    assign mis    = mem_op & misal(f_size, f_addr[1:0]);
    assign direct = f_exc | mis | ~mem_op;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state != REQ) begin
            cnt <= '0;
        end else if (!dm.dm_ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign to_hit = (state == REQ) && !dm.dm_ack
                  && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign finish = (capture && direct)
                  || ((state == REQ) && (dm.dm_ack || to_hit));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (MEM_valid) nstate = direct ? DONE : REQ;
            REQ:     if (dm.dm_ack || to_hit) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        lb = dm.dm_rdata[{h_addr[1:0], 3'b000} +: 8];
        lh = h_addr[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        unique case (1'b1)
            h_size[1]:         ld_ext = dm.dm_rdata;
            (h_size == 2'b01): ld_ext = {{16{~h_uns & lh[15]}}, lh};
            default:           ld_ext = {{24{~h_uns & lb[7]}}, lb};
        endcase
    end

    always_comb begin
        exc_f = f_exc | mis | to_hit;
        if (f_exc)       exc_t = f_etype;
        else if (mis)    exc_t = {1'b0, ~f_load};
        else if (to_hit) exc_t = 2'b10;
        else             exc_t = 2'b00;
        // A faulting load has no data; it carries the address instead.
        wb    = (f_load & ~exc_f) ? ld_ext : 32'(f_addr);
        bus_d = {exc_f, exc_t, f_rfw, f_dest, wb, f_pc};
        mf_d  = ~f_exc & (mis | to_hit);
        mt_d  = mf_d ? exc_t : 2'b00;
    end

    always_comb begin
        unique case (1'b1)
            h_size[1]: begin
                lane_wen = 4'b1111;
                lane_wd  = h_wdata;
            end
            (h_size == 2'b01): begin
                lane_wen = h_addr[1] ? 4'b1100 : 4'b0011;
                lane_wd  = {2{h_wdata[15:0]}};
            end
            default: begin
                lane_wen = 4'b0001 << h_addr[1:0];
                lane_wd  = {24'b0, h_wdata[7:0]} << {h_addr[1:0], 3'b000};
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_load  <= 1'b0;
            h_store <= 1'b0;
            h_uns   <= 1'b0;
            h_rfw   <= 1'b0;
            h_exc   <= 1'b0;
            h_size  <= 2'b00;
            h_etype <= 2'b00;
            h_addr  <= '0;
            h_wdata <= '0;
            h_pc    <= '0;
            h_dest  <= '0;
        end else if (capture) begin
            h_load  <= in_load;
            h_store <= in_store;
            h_uns   <= in_unsigned;
            h_rfw   <= in_rf_wen;
            h_exc   <= in_exc_flag;
            h_size  <= in_size;
            h_etype <= in_exc_type;
            h_addr  <= in_addr;
            h_wdata <= in_wdata;
            h_pc    <= in_pc;
            h_dest  <= in_rf_wdest;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
            mf_q  <= 1'b0;
            mt_q  <= 2'b00;
        end else if (finish) begin
            bus_q <= bus_d;
            mf_q  <= mf_d;
            mt_q  <= mt_d;
        end
    end

    always_comb begin
        dm.dm_req  = (state == REQ);
        dm.dm_wen  = 4'b0000;
        if ((state == REQ) && h_store && !h_load) begin
            dm.dm_wen = lane_wen;
        end
        dm.dm_addr         = {h_addr[ADDR_W-1:2], 2'b00};
        dm.dm_wdata        = lane_wd;
        MEM_over           = (state == DONE);
        busy               = (state != IDLE);
        MEM_pc             = h_pc;
        MEM_WB_bus         = bus_q;
        mem_exception_flag = mf_q;
        mem_exception_type = mt_q;
    end

endmodule

// File: tb/tb_mem_hs_stage.sv
// Bench for mem_hs_stage: directed table, reset/timeout
// sequences, random ops against a behavioural model.
module tb_mem_hs_stage;

    localparam int TO = 15;

    typedef struct {
        logic        ld, st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        rfw;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        exc;
        logic [1:0]  et;
        logic [31:0] rdata;
        int          ack;
        logic        noise;
    } op_t;

    typedef struct {
        int          rq, lat;
        logic [3:0]  wen;
        logic [31:0] wdata, wb;
        logic        wb_chk, flag;
        logic [1:0]  typ;
        logic        mf;
        logic [1:0]  mt;
    } exp_t;

    typedef struct {
        int          rq, ov, lat;
        logic [3:0]  wen;
        logic [31:0] wd, ad;
        logic        wen_off, busy1;
        logic [72:0] bus;
        logic        mf;
        logic [1:0]  mt;
    } res_t;

    typedef struct {
        logic        ld, st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        exc;
        logic [1:0]  et;
        logic [31:0] rdata;
        int          ack;
        int          rq;
        logic [3:0]  wen;
        logic [31:0] wd, wb;
        logic        flag;
        logic [1:0]  typ;
        logic        mf;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        MEM_valid, in_load, in_store, in_unsigned;
    logic [1:0]  in_size, in_exc_type;
    logic [31:0] in_addr, in_wdata, in_pc;
    logic        in_rf_wen, in_exc_flag;
    logic [4:0]  in_rf_wdest;
    logic        MEM_over, busy;
    logic [72:0] MEM_WB_bus;
    logic [31:0] MEM_pc;
    logic        mem_exception_flag;
    logic [1:0]  mem_exception_type;

    int total = 0;
    int bad   = 0;

    vec_t tbl[15];
    op_t  o;
    exp_t e;
    res_t r;

    always #5 clk = ~clk;

    mem_hs_stage_if #(.ADDR_W(32)) dmif ();

    mem_hs_stage dut (
        .clk                (clk),
        .resetn             (resetn),
        .MEM_valid          (MEM_valid),
        .in_load            (in_load),
        .in_store           (in_store),
        .in_size            (in_size),
        .in_unsigned        (in_unsigned),
        .in_addr            (in_addr),
        .in_wdata           (in_wdata),
        .in_rf_wen          (in_rf_wen),
        .in_rf_wdest        (in_rf_wdest),
        .in_pc              (in_pc),
        .in_exc_flag        (in_exc_flag),
        .in_exc_type        (in_exc_type),
        .dm                 (dmif),
        .MEM_over           (MEM_over),
        .MEM_WB_bus         (MEM_WB_bus),
        .MEM_pc             (MEM_pc),
        .busy               (busy),
        .mem_exception_flag (mem_exception_flag),
        .mem_exception_type (mem_exception_type)
    );

    task automatic chk(input string nm, input logic [72:0] a,
                       input logic [72:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, x);
        end
    endtask

    function automatic exp_t model(input op_t op);
        exp_t        m;
        int          w, a;
        logic        mem, mis, direct, berr;
        logic [63:0] v, msk;
        w      = op.sz[1] ? 4 : (op.sz[0] ? 2 : 1);
        a      = int'(op.addr[1:0]);
        mem    = op.ld || op.st;
        mis    = mem && ((a % w) != 0);
        direct = op.exc || mis || !mem;
        berr   = !direct && (op.ack == 0);
        m.rq   = direct ? 0 : (berr ? TO : op.ack);
        m.lat  = m.rq + 1;
        m.wen   = 4'h0;
        m.wdata = 32'h0;
        if (op.st && !op.ld) begin
            m.wen = 4'(((1 << w) - 1) << a);
            if (w == 1)      m.wdata = (op.wdata & 32'hFF) << (8 * a);
            else if (w == 2) m.wdata = (op.wdata & 32'hFFFF) * 32'h10001;
            else             m.wdata = op.wdata;
        end
        msk = (64'd1 << (8 * w)) - 64'd1;
        v   = (64'(op.rdata) >> (8 * a)) & msk;
        if (!op.uns && v[8 * w - 1]) v = v | ~msk;
        m.flag = op.exc || mis || berr;
        if (op.exc)    m.typ = op.et;
        else if (mis)  m.typ = op.ld ? 2'd0 : 2'd1;
        else if (berr) m.typ = 2'd2;
        else           m.typ = 2'd0;
        m.mf     = !op.exc && (mis || berr);
        m.mt     = m.mf ? m.typ : 2'd0;
        m.wb     = (op.ld && !m.flag) ? v[31:0] : op.addr;
        m.wb_chk = !(op.ld && m.flag);
        return m;
    endfunction

    task automatic run_op(input op_t op, output res_t rs);
        rs.rq = 0; rs.ov = 0; rs.lat = 0;
        rs.wen = 4'h0; rs.wd = 32'h0; rs.ad = 32'h0;
        rs.wen_off = 1'b0; rs.busy1 = 1'b0;
        rs.bus = '0; rs.mf = 1'b0; rs.mt = 2'b00;
        MEM_valid   = 1'b1;
        in_load     = op.ld;
        in_store    = op.st;
        in_size     = op.sz;
        in_unsigned = op.uns;
        in_addr     = op.addr;
        in_wdata    = op.wdata;
        in_rf_wen   = op.rfw;
        in_rf_wdest = op.dest;
        in_pc       = op.pc;
        in_exc_flag = op.exc;
        in_exc_type = op.et;
        dmif.dm_ack = 1'b0;
        @(posedge clk);
        #1;
        if (op.noise) begin
            in_pc       = ~op.pc;
            in_addr     = op.addr ^ 32'h5;
            in_load     = 1'b0;
            in_store    = 1'b0;
            in_exc_flag = 1'b0;
        end else begin
            MEM_valid = 1'b0;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) rs.busy1 = busy;
            if (dmif.dm_req) begin
                rs.rq++;
                rs.wen = rs.wen | dmif.dm_wen;
                rs.wd  = dmif.dm_wdata;
                rs.ad  = dmif.dm_addr;
                dmif.dm_ack   = (rs.rq == op.ack);
                dmif.dm_rdata = (rs.rq == op.ack) ? op.rdata : $urandom;
            end else begin
                if (dmif.dm_wen != 4'h0) rs.wen_off = 1'b1;
                dmif.dm_ack = 1'b0;
            end
            if (MEM_over) begin
                rs.ov++;
                if (rs.ov == 1) begin
                    rs.lat = n;
                    rs.bus = MEM_WB_bus;
                    rs.mf  = mem_exception_flag;
                    rs.mt  = mem_exception_type;
                end
            end
            if (op.noise && rs.ov > 0 && n > rs.lat) MEM_valid = 1'b0;
            if (rs.ov > 0 && n >= rs.lat + 2) break;
        end
        MEM_valid   = 1'b0;
        dmif.dm_ack = 1'b0;
    endtask

    task automatic check_op(input string tg, input op_t op,
                            input exp_t ex, input res_t rs);
        chk({tg, ".over"}, 73'(rs.ov), 73'(1));
        chk({tg, ".req"}, 73'(rs.rq), 73'(ex.rq));
        chk({tg, ".lat"}, 73'(rs.lat), 73'(ex.lat));
        chk({tg, ".busy"}, 73'(rs.busy1), 73'(1));
        chk({tg, ".flag"}, 73'(rs.bus[72]), 73'(ex.flag));
        chk({tg, ".type"}, 73'(rs.bus[71:70]), 73'(ex.typ));
        chk({tg, ".rfwen"}, 73'(rs.bus[69]), 73'(op.rfw));
        chk({tg, ".dest"}, 73'(rs.bus[68:64]), 73'(op.dest));
        chk({tg, ".pc"}, 73'(rs.bus[31:0]), 73'(op.pc));
        if (ex.wb_chk)
            chk({tg, ".wb"}, 73'(rs.bus[63:32]), 73'(ex.wb));
        chk({tg, ".mflag"}, 73'(rs.mf), 73'(ex.mf));
        if (ex.mf) chk({tg, ".mtype"}, 73'(rs.mt), 73'(ex.mt));
        if (ex.rq > 0) begin
            chk({tg, ".addr"}, 73'(rs.ad), 73'({op.addr[31:2], 2'b00}));
            chk({tg, ".wen"}, 73'(rs.wen), 73'(ex.wen));
            if (ex.wen != 4'h0)
                chk({tg, ".wdata"}, 73'(rs.wd), 73'(ex.wdata));
        end
        chk({tg, ".wenoff"}, 73'(rs.wen_off), 73'(0));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 2'd0,
                    32'hDEADBEEF, 3, 3, 4'h0, 32'h0, 32'hDEADBEEF,
                    1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0, 2'd0,
                    32'h80123456, 1, 1, 4'h0, 32'h0, 32'hFFFFFF80,
                    1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0, 2'd0,
                    32'h80123456, 2, 2, 4'h0, 32'h0, 32'h00000080,
                    1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 1'b0,
                    2'd0, 32'h0, 1, 1, 4'hC, 32'hABCDABCD, 32'h102,
                    1'b0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h1234ABCD, 1'b0,
                    2'd0, 32'h0, 2, 2, 4'h2, 32'h0000CD00, 32'h101,
                    1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1'b0, 2'd0,
                    32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h106, 32'h55, 1'b0, 2'd0,
                    32'h0, 1, 0, 4'h0, 32'h0, 32'h106, 1'b1, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h77, 1'b1, 2'd3,
                    32'h0, 1, 0, 4'h0, 32'h0, 32'h200, 1'b1, 2'd3, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b0, 2'd0,
                    32'h80011234, 1, 1, 4'h0, 32'h0, 32'hFFFF8001,
                    1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 1'b0, 2'd0,
                    32'h1234F00D, 2, 2, 4'h0, 32'h0, 32'h0000F00D,
                    1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0,
                    2'd0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h12345678,
                    1'b0, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 1'b0, 2'd0,
                    32'hCAFEF00D, 4, 4, 4'h0, 32'h0, 32'hCAFEF00D,
                    1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h204, 32'hA5A51234, 1'b0,
                    2'd0, 32'h0, 1, 1, 4'hF, 32'hA5A51234, 32'h204,
                    1'b0, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 1'b0, 2'd0,
                    32'h00AB0000, 1, 1, 4'h0, 32'h0, 32'h000000AB,
                    1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h9, 1'b0, 2'd0,
                    32'h0, 1, 0, 4'h0, 32'h0, 32'h101, 1'b1, 2'd1, 1'b1};

        resetn = 1'b0;
        MEM_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0;
        in_wdata = '0; in_rf_wen = 1'b0; in_rf_wdest = '0;
        in_pc = '0; in_exc_flag = 1'b0; in_exc_type = 2'd0;
        dmif.dm_ack = 1'b0;
        dmif.dm_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst.req", 73'(dmif.dm_req), 73'(0));
        chk("rst.wen", 73'(dmif.dm_wen), 73'(0));
        chk("rst.over", 73'(MEM_over), 73'(0));
        chk("rst.busy", 73'(busy), 73'(0));
        chk("rst.mflag", 73'(mem_exception_flag), 73'(0));
        chk("rst.mtype", 73'(mem_exception_type), 73'(0));
        chk("rst.bus", MEM_WB_bus, 73'(0));
        chk("rst.pc", 73'(MEM_pc), 73'(0));
        chk("rst.addr", 73'(dmif.dm_addr), 73'(0));
        chk("rst.wdata", 73'(dmif.dm_wdata), 73'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            o.ld = tbl[i].ld;     o.st = tbl[i].st;
            o.sz = tbl[i].sz;     o.uns = tbl[i].uns;
            o.addr = tbl[i].addr; o.wdata = tbl[i].wdata;
            o.rfw = tbl[i].ld;    o.dest = 5'(i + 1);
            o.pc = 32'h400 + 32'(4 * i);
            o.exc = tbl[i].exc;   o.et = tbl[i].et;
            o.rdata = tbl[i].rdata;
            o.ack = tbl[i].ack;
            o.noise = ((i % 3) == 1);
            e.rq = tbl[i].rq;     e.lat = tbl[i].rq + 1;
            e.wen = tbl[i].wen;   e.wdata = tbl[i].wd;
            e.wb = tbl[i].wb;     e.flag = tbl[i].flag;
            e.wb_chk = !(tbl[i].ld && tbl[i].flag);
            e.typ = tbl[i].typ;   e.mf = tbl[i].mf;
            e.mt = tbl[i].typ;
            run_op(o, r);
            check_op($sformatf("vec%0d", i), o, e, r);
        end

        MEM_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        in_size = 2'd2; in_addr = 32'h300; in_exc_flag = 1'b0;
        @(posedge clk);
        #1 MEM_valid = 1'b0;
        @(negedge clk);
        chk("rstreq.pre", 73'(dmif.dm_req), 73'(1));
        #2 resetn = 1'b0;
        #1;
        chk("rstreq.req", 73'(dmif.dm_req), 73'(0));
        chk("rstreq.busy", 73'(busy), 73'(0));
        @(negedge clk);
        resetn = 1'b1;
        chk("rstreq.bus", MEM_WB_bus, 73'(0));
        dmif.dm_ack = 1'b1;
        @(negedge clk);
        dmif.dm_ack = 1'b0;
        chk("rstreq.over", 73'(MEM_over), 73'(0));
        chk("rstreq.idle", 73'(busy), 73'(0));

`ifdef MEM_TIMEOUT_EN
        o.ld = 1'b1; o.st = 1'b0; o.sz = 2'd2; o.uns = 1'b0;
        o.addr = 32'h400; o.wdata = '0; o.rfw = 1'b1; o.dest = 5'd9;
        o.pc = 32'h900; o.exc = 1'b0; o.et = 2'd0; o.rdata = '0;
        o.ack = 0; o.noise = 1'b0;
        run_op(o, r);
        check_op("tmo", o, model(o), r);
        dmif.dm_ack = 1'b1;
        @(negedge clk);
        dmif.dm_ack = 1'b0;
        chk("tmo.lateack", 73'(MEM_over), 73'(0));
`endif

        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 3);
            o.ld = (k == 1) || (k == 3);
            o.st = (k == 2);
            o.sz = 2'($urandom_range(0, 3));
            o.uns = 1'($urandom_range(0, 1));
            o.addr = $urandom;
            o.wdata = $urandom;
            o.rfw = 1'($urandom_range(0, 1));
            o.dest = 5'($urandom_range(0, 31));
            o.pc = $urandom;
            o.exc = ($urandom_range(0, 7) == 0);
            o.et = 2'($urandom_range(0, 3));
            o.rdata = $urandom;
            o.ack = $urandom_range(1, 4);
            o.noise = 1'($urandom_range(0, 1));
            run_op(o, r);
            check_op($sformatf("rnd%0d", i), o, model(o), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
